// File: rtl/tmp_pkg.sv
// tmp_pkg: shared widths, FSM states and saturation helper for the temperature result path
package tmp_pkg;
   localparam int TMP_CNT_W       = 8;
   localparam int TMP_FRAMES_LOG2 = 3;
   localparam int TMP_OUT_W       = 10;
   typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, ACCUM = 2'd2, DONE = 2'd3} tmp_state_e;
   function automatic logic signed [31:0] sat_s(input logic signed [31:0] v, input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      return v > hi ? hi : v < lo ? lo : v;
   endfunction
endpackage

// File: rtl/tmp_evt_counter.sv
// tmp_evt_counter: saturating event counter with clear and restart-at-0/1 load
module tmp_evt_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             ld,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);
   // clr wins; ld restarts so an event in the load cycle counts toward the new frame
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (ld) cnt <= CNT_W'(inc);
      else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/tmp_result_accum.sv
// tmp_result_accum: per-frame sink/source delta, 2^FRAMES_LOG2 averaging and valid/ready result
module tmp_result_accum
   import tmp_pkg::*;
#(
   parameter int CNT_W       = TMP_CNT_W,
   parameter int FRAMES_LOG2 = TMP_FRAMES_LOG2,
   parameter int OUT_W       = TMP_OUT_W
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    setup_done,
   input  logic                    snk_evt,
   input  logic                    src_evt,
   input  logic                    frame_done,
   output logic signed [OUT_W-1:0] data,
   output logic                    valid,
   input  logic                    ready,
   output logic                    overrun,
   output logic                    busy
);
   localparam int ACC_W = CNT_W + 1 + FRAMES_LOG2;
   tmp_state_e state, state_nx;
   logic [CNT_W-1:0] snk_cnt, src_cnt;
   logic [FRAMES_LOG2-1:0] frame_idx;
   logic signed [ACC_W-1:0] acc, acc_sh;
   logic signed [CNT_W:0] delta;
   logic go, cnt_clr, cnt_ld, cnt_en, load, enable_q;
   assign go      = enable && setup_done;
   assign cnt_clr = !enable || state == IDLE || (state == COUNT && !setup_done);
   assign cnt_ld  = state == ACCUM;
   assign cnt_en  = state != IDLE;
   assign load    = state == DONE && enable;
   assign delta   = $signed({1'b0, snk_cnt}) - $signed({1'b0, src_cnt});
   assign acc_sh  = acc >>> FRAMES_LOG2;
   assign busy    = state == COUNT || state == ACCUM;
   tmp_evt_counter #(.CNT_W(CNT_W)) u_snk (
      .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .ld(cnt_ld), .inc(snk_evt && cnt_en), .cnt(snk_cnt)
   );
   tmp_evt_counter #(.CNT_W(CNT_W)) u_src (
      .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .ld(cnt_ld), .inc(src_evt && cnt_en), .cnt(src_cnt)
   );
   // next state: enable low aborts from anywhere, a setup_done drop discards the open frame
   always_comb
      state_nx = !enable ? IDLE :
                 state == IDLE  ? (go ? COUNT : IDLE) :
                 state == COUNT ? (!setup_done ? IDLE : frame_done ? ACCUM : COUNT) :
                 state == ACCUM ? (&frame_idx ? DONE : COUNT) :
                 (go ? COUNT : IDLE);
   // FSM, frame accumulator and frame index
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state     <= IDLE;
         acc       <= '0;
         frame_idx <= '0;
      end else begin
         state <= state_nx;
         if (!enable || state == DONE) begin
            acc       <= '0;
            frame_idx <= '0;
         end else if (state == ACCUM) begin
            acc       <= acc + ACC_W'(delta);
            frame_idx <= frame_idx + 1'b1;
         end
      end
   // one-deep result register with sticky overrun, cleared on an enable rising edge
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         data     <= '0;
         valid    <= 1'b0;
         overrun  <= 1'b0;
         enable_q <= 1'b0;
      end else begin
         enable_q <= enable;
         if (load) begin
            data  <= OUT_W'(sat_s(32'(acc_sh), OUT_W));
            valid <= 1'b1;
         end else if (valid && ready) valid <= 1'b0;
         if (enable && !enable_q) overrun <= 1'b0;
         else if (load && valid && !ready) overrun <= 1'b1;
      end
endmodule

// File: tb/tb_tmp_result_accum.sv
// tb_tmp_result_accum: directed self-checking bench for tmp_result_accum
module tb_tmp_result_accum;
   logic clk = 1'b0;
   logic reset_n, enable, setup_done, snk_evt, src_evt, frame_done, ready;
   logic signed [9:0] data;
   logic signed [7:0] data8;
   logic valid, overrun, busy, valid8, overrun8, busy8;
   int n_chk = 0;
   int n_fail = 0;

   tmp_result_accum dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .setup_done(setup_done),
      .snk_evt(snk_evt), .src_evt(src_evt), .frame_done(frame_done),
      .data(data), .valid(valid), .ready(ready), .overrun(overrun), .busy(busy)
   );

   tmp_result_accum #(.OUT_W(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .setup_done(setup_done),
      .snk_evt(snk_evt), .src_evt(src_evt), .frame_done(frame_done),
      .data(data8), .valid(valid8), .ready(ready), .overrun(overrun8), .busy(busy8)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic s, input logic c, input logic f);
      snk_evt = s;
      src_evt = c;
      frame_done = f;
      @(posedge clk);
      #1;
      snk_evt = 1'b0;
      src_evt = 1'b0;
      frame_done = 1'b0;
   endtask

   task automatic run_frame(input int ns, input int nc, input logic fs, input logic fc, input logic a_s, input logic a_c);
      for (int i = 0; i < ((ns > nc) ? ns : nc); i++) cyc(i < ns, i < nc, 1'b0);
      cyc(fs, fc, 1'b1);
      cyc(a_s, a_c, 1'b0);
   endtask

   task automatic start();
      enable = 1'b0;
      setup_done = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      enable = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      enable = 1'b0;
      setup_done = 1'b0;
      ready = 1'b0;
      snk_evt = 1'b0;
      src_evt = 1'b0;
      frame_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if ({data, valid, overrun, busy} !== 13'd0) begin
         $display("FAIL reset_outputs: got data=%0d valid=%0b overrun=%0b busy=%0b, expected all 0", data, valid, overrun, busy);
         n_fail++;
      end
      reset_n = 1'b1;
   endtask

   task automatic test_uniform();
      start();
      ready = 1'b1;
      for (int f = 0; f < 8; f++) run_frame(20, 12, 1'b0, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL uniform_done_cycle: got valid=%0b busy=%0b, expected 0 0", valid, busy);
         n_fail++;
      end
      cyc(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (valid !== 1'b1 || data !== 10'sd8) begin
         $display("FAIL uniform_result: got valid=%0b data=%0d, expected 1 8", valid, data);
         n_fail++;
      end
      cyc(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (valid !== 1'b0) begin
         $display("FAIL uniform_valid_drop: got valid=%0b, expected 0", valid);
         n_fail++;
      end
   endtask

   task automatic test_negative();
      start();
      for (int f = 0; f < 8; f++) run_frame(0, (f == 7) ? 4 : 3, 1'b0, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (dut.acc !== -12'sd25) begin
         $display("FAIL negative_acc: got %0d, expected -25", dut.acc);
         n_fail++;
      end
      cyc(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (valid !== 1'b1 || data !== -10'sd4 || overrun !== 1'b0) begin
         $display("FAIL negative_result: got valid=%0b data=%0d overrun=%0b, expected 1 -4 0", valid, data, overrun);
         n_fail++;
      end
   endtask

   task automatic test_saturation();
      start();
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < 299; i++) cyc(1'b1, 1'b0, 1'b0);
         cyc(1'b1, 1'b0, 1'b1);
         if (f == 0) begin
            n_chk++;
            if (dut.snk_cnt !== 8'd255) begin
               $display("FAIL sat_counter: got %0d, expected 255", dut.snk_cnt);
               n_fail++;
            end
         end
         cyc(1'b0, 1'b0, 1'b0);
      end
      cyc(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (data !== 10'sd255) begin
         $display("FAIL sat_out10: got %0d, expected 255", data);
         n_fail++;
      end
      n_chk++;
      if (data8 !== 8'sd127) begin
         $display("FAIL sat_out8: got %0d, expected 127", data8);
         n_fail++;
      end
   endtask

   task automatic test_simultaneous();
      start();
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);
         for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
         cyc(1'b1, 1'b1, 1'b1);
         n_chk++;
         if (dut.snk_cnt !== ((f == 0) ? 8'd14 : 8'd15) || dut.src_cnt !== ((f == 0) ? 8'd11 : 8'd12)) begin
            $display("FAIL simul_close_f%0d: got snk=%0d src=%0d, expected %0d %0d", f, dut.snk_cnt, dut.src_cnt, (f == 0) ? 14 : 15, (f == 0) ? 11 : 12);
            n_fail++;
         end
         cyc(1'b1, 1'b1, 1'b1);
         n_chk++;
         if (dut.snk_cnt !== 8'd1 || dut.src_cnt !== 8'd1) begin
            $display("FAIL simul_accum_load_f%0d: got snk=%0d src=%0d, expected 1 1", f, dut.snk_cnt, dut.src_cnt);
            n_fail++;
         end
      end
      cyc(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (valid !== 1'b1 || data !== 10'sd3) begin
         $display("FAIL simul_result: got valid=%0b data=%0d, expected 1 3", valid, data);
         n_fail++;
      end
   endtask

   task automatic test_setup_drop();
      start();
      for (int f = 0; f < 3; f++) run_frame(8, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 1'b0);
      setup_done = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (busy !== 1'b0 || dut.frame_idx !== 3'd3 || dut.acc !== 12'sd24) begin
         $display("FAIL setup_drop_state: got busy=%0b idx=%0d acc=%0d, expected 0 3 24", busy, dut.frame_idx, dut.acc);
         n_fail++;
      end
      setup_done = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      for (int f = 0; f < 5; f++) run_frame(8, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (valid !== 1'b1 || data !== 10'sd8) begin
         $display("FAIL setup_drop_result: got valid=%0b data=%0d, expected 1 8", valid, data);
         n_fail++;
      end
   endtask

   task automatic test_backpressure();
      start();
      ready = 1'b0;
      for (int f = 0; f < 8; f++) run_frame(2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (valid !== 1'b1 || data !== 10'sd2 || overrun !== 1'b0) begin
         $display("FAIL bp_first: got valid=%0b data=%0d overrun=%0b, expected 1 2 0", valid, data, overrun);
         n_fail++;
      end
      for (int f = 0; f < 4; f++) run_frame(5, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (data !== 10'sd2 || valid !== 1'b1) begin
         $display("FAIL bp_hold: got valid=%0b data=%0d, expected 1 2", valid, data);
         n_fail++;
      end
      for (int f = 0; f < 4; f++) run_frame(5, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (valid !== 1'b1 || data !== 10'sd5 || overrun !== 1'b1) begin
         $display("FAIL bp_second: got valid=%0b data=%0d overrun=%0b, expected 1 5 1", valid, data, overrun);
         n_fail++;
      end
      ready = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (valid !== 1'b0 || overrun !== 1'b1) begin
         $display("FAIL bp_drain: got valid=%0b overrun=%0b, expected 0 1", valid, overrun);
         n_fail++;
      end
      enable = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      enable = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (overrun !== 1'b0) begin
         $display("FAIL bp_overrun_clear: got %0b, expected 0", overrun);
         n_fail++;
      end
   endtask

   task automatic test_abort();
      start();
      for (int f = 0; f < 5; f++) run_frame(4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      enable = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (busy !== 1'b0 || dut.acc !== 12'sd0 || dut.frame_idx !== 3'd0 || valid !== 1'b0 || data !== 10'sd5) begin
         $display("FAIL abort_clear: got busy=%0b acc=%0d idx=%0d valid=%0b data=%0d, expected 0 0 0 0 5", busy, dut.acc, dut.frame_idx, valid, data);
         n_fail++;
      end
      enable = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
      reset_n = 1'b0;
      #1;
      n_chk++;
      if ({data, valid, overrun, busy} !== 13'd0) begin
         $display("FAIL abort_reset: got data=%0d valid=%0b overrun=%0b busy=%0b, expected all 0", data, valid, overrun, busy);
         n_fail++;
      end
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      start();
      for (int f = 0; f < 8; f++) run_frame(6, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (valid !== 1'b1 || data !== 10'sd6) begin
         $display("FAIL abort_recover: got valid=%0b data=%0d, expected 1 6", valid, data);
         n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_uniform();
      test_negative();
      test_saturation();
      test_simultaneous();
      test_setup_drop();
      test_backpressure();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
